// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grants one requester at a time and holds the
// grant across multi-flit packets until the granted input's tail flit fires.
module rr_packet_arbiter #(
  parameter int INPUTS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INPUTS-1:0]         req_i,
  input  logic [INPUTS-1:0]         last_i,
  input  logic                      ready_i,
  output logic [INPUTS-1:0]         grant_o,
  output logic                      valid_o,
  output logic [$clog2(INPUTS)-1:0] grant_id_o
);

  localparam int IDW = $clog2(INPUTS);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [INPUTS-1:0]   prio_q, prio_d;
  logic [INPUTS-1:0]   lock_vec_q, lock_vec_d;
  logic [INPUTS-1:0]   grant;
  logic [IDW-1:0]      grant_id;
  logic                fire;
  logic                tail;
  logic                found;
  int                  prio_idx;
  int                  idx;

  function automatic logic [INPUTS-1:0] rotl1(input logic [INPUTS-1:0] v);
    return {v[INPUTS-2:0], v[INPUTS-1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      prio_q     <= {{(INPUTS-1){1'b0}}, 1'b1};
      lock_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_vec_q <= lock_vec_d;
    end
  end

  // Grant selection: upward scan from the priority position, wrapping at the top.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    prio_idx = 0;
    idx      = 0;
    for (int i = 0; i < INPUTS; i++) begin
      if (prio_q[i]) prio_idx = i;
    end
    if (state_q == HOLD) begin
      grant = lock_vec_q & req_i;
    end else begin
      for (int k = 0; k < INPUTS; k++) begin
        idx = prio_idx + k;
        if (idx >= INPUTS) idx = idx - INPUTS;
        if (!found && req_i[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  assign fire = (|grant) & ready_i;
  assign tail = |(grant & last_i);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_vec_d = lock_vec_q;
    if (fire) begin
      case (state_q)
        ARB: begin
          if (tail) begin
            prio_d = rotl1(grant);
          end else begin
            state_d    = HOLD;
            lock_vec_d = grant;
          end
        end
        HOLD: begin
          if (tail) begin
            state_d    = ARB;
            prio_d     = rotl1(lock_vec_q);
            lock_vec_d = '0;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign grant_o    = grant;
  assign valid_o    = |grant;
  assign grant_id_o = grant_id;

endmodule
